bless_inject_ctrl: RTL and testbench

BLESS_INJECT_CTRL -- requirements
Module: bless_inject_ctrl

---
 rtl/bless_inject_ctrl_pkg.sv | 47 ++++
 rtl/inject_fifo.sv | 51 +++++
 rtl/bless_inject_ctrl.sv | 115 +++++++++++
 tb/tb_bless_inject_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bless_inject_ctrl_pkg.sv
// rtl/bless_inject_ctrl_pkg.sv - shared flit layout, port indices and routing helper
package bless_inject_ctrl_pkg;

   localparam int WIDTH_DATA = 32;
   localparam int WIDTH_HDR  = 24;
   localparam int WIDTH_PORT = WIDTH_HDR + WIDTH_DATA;
   localparam int WIDTH_PV   = 5;

   localparam int POS_Y_LSB  = WIDTH_DATA;
   localparam int POS_X_LSB  = POS_Y_LSB + 4;
   localparam int TIME_LSB   = POS_X_LSB + 4;
   localparam int FLITID_LSB = TIME_LSB + 8;
   localparam int PKTID_LSB  = FLITID_LSB + 2;

   localparam int PORT_W     = 0;
   localparam int PORT_E     = 1;
   localparam int PORT_S     = 2;
   localparam int PORT_N     = 3;
   localparam int PORT_LOCAL = 4;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_INJECT  = 2'd1;
   localparam logic [1:0] ST_BLOCKED = 2'd2;

   typedef struct packed {
      logic [5:0]            pktid;
      logic [1:0]            flitid;
      logic [7:0]            tstamp;
      logic [3:0]            pos_x;
      logic [3:0]            pos_y;
      logic [WIDTH_DATA-1:0] data;
   } flit_t;

   // Dimension-agnostic productive ports: every direction that reduces distance is set.
   function automatic logic [WIDTH_PV-1:0] route_pv(input logic [3:0] px, input logic [3:0] py,
                                                    input logic [3:0] cx, input logic [3:0] cy);
      logic [WIDTH_PV-1:0] pv;
      pv             = '0;
      pv[PORT_E]     = (px > cx);
      pv[PORT_W]     = (px < cx);
      pv[PORT_N]     = (py > cy);
      pv[PORT_S]     = (py < cy);
      pv[PORT_LOCAL] = (px == cx) && (py == cy);
      return pv;
   endfunction

endpackage

// File: rtl/inject_fifo.sv
// rtl/inject_fifo.sv - local injection FIFO, head readable combinationally
module inject_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic             o_empty,
   output logic             o_full
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_wr_en;
   logic             w_rd_en;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign w_wr_en = i_push & ~o_full;
   assign w_rd_en = i_pop & ~o_empty;
   assign o_head  = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_wr_ptr] <= i_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr_en, w_rd_en})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/bless_inject_ctrl.sv
// rtl/bless_inject_ctrl.sv - bufferless router local injection with token throttle and starvation flag
module bless_inject_ctrl
   import bless_inject_ctrl_pkg::*;
#(
   parameter int         DEPTH      = 4,
   parameter logic [3:0] X_CUR      = 4'd0,
   parameter logic [3:0] Y_CUR      = 4'd0,
   parameter int         INJ_MAX    = 4,
   parameter int         WINDOW     = 16,
   parameter int         STARVE_LIM = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  coreValid,
   input  logic [WIDTH_PORT-1:0] coreFlit,
   output logic                  coreReady,
   input  logic [3:0]            linkValid,
   input  logic                  throttleEn,
   output logic [WIDTH_PORT-1:0] dinLocal,
   output logic [WIDTH_PV-1:0]   PVLocal,
   output logic                  injValid,
   output logic                  starve
);
   localparam int TOK_W = $clog2(INJ_MAX + 1);
   localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam int STV_W = $clog2(STARVE_LIM + 1);
   localparam logic [TOK_W-1:0] TOK_MAX  = TOK_W'(INJ_MAX);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
   localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIM);

   logic                  w_empty;
   logic                  w_full;
   logic                  w_inj;
   logic [WIDTH_PORT-1:0] w_head_raw;
   flit_t                 w_head;
   flit_t                 w_out;
   logic [1:0]            w_state_nxt;
   logic [STV_W-1:0]      w_starve_cnt_nxt;
   logic [7:0]            r_time;
   logic [WIN_W-1:0]      r_win;
   logic [TOK_W-1:0]      r_tokens;
   logic [STV_W-1:0]      r_starve_cnt;
   logic                  r_starve;
   logic [1:0]            r_state;

   inject_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH_PORT)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (coreValid),
      .i_data  (coreFlit),
      .i_pop   (w_inj),
      .o_head  (w_head_raw),
      .o_empty (w_empty),
      .o_full  (w_full)
   );

   assign w_head    = flit_t'(w_head_raw);
   assign coreReady = ~w_full;
   // A free output slot exists only if fewer than four links carry flits.
   assign w_inj     = ~w_empty & ~(&linkValid) & (~throttleEn | (r_tokens != '0));
   assign injValid  = w_inj;
   assign starve    = r_starve;

   always_comb begin
      w_out = '0;
      if (w_inj) begin
         w_out        = w_head;
         w_out.tstamp = r_time;
      end
   end

   assign dinLocal = w_out;
   assign PVLocal  = w_inj ? route_pv(w_head.pos_x, w_head.pos_y, X_CUR, Y_CUR) : '0;

   always_comb begin
      w_state_nxt = ST_BLOCKED;
      if (w_empty)    w_state_nxt = ST_IDLE;
      else if (w_inj) w_state_nxt = ST_INJECT;
   end

   // A fresh blocked run restarts the count at one.
   always_comb begin
      w_starve_cnt_nxt = '0;
      if (w_state_nxt == ST_BLOCKED) begin
         if (r_state != ST_BLOCKED)        w_starve_cnt_nxt = STV_W'(1);
         else if (r_starve_cnt != STV_MAX) w_starve_cnt_nxt = r_starve_cnt + 1'b1;
         else                              w_starve_cnt_nxt = r_starve_cnt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_time       <= '0;
         r_win        <= '0;
         r_tokens     <= TOK_MAX;
         r_starve_cnt <= '0;
         r_starve     <= 1'b0;
         r_state      <= ST_IDLE;
      end else begin
         r_time       <= r_time + 8'd1;
         r_state      <= w_state_nxt;
         r_starve_cnt <= w_starve_cnt_nxt;
         r_starve     <= (w_starve_cnt_nxt >= STV_MAX);
         // Reload wins over a same-edge injection so each window starts full.
         if (r_win == WIN_LAST) begin
            r_win    <= '0;
            r_tokens <= TOK_MAX;
         end else begin
            r_win <= r_win + 1'b1;
            if (w_inj && (r_tokens != '0)) r_tokens <= r_tokens - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bless_inject_ctrl.sv
// tb/tb_bless_inject_ctrl.sv - randomized self-checking bench with queue-based reference model
module tb_bless_inject_ctrl;
   import bless_inject_ctrl_pkg::*;

   localparam int         DEPTH      = 4;
   localparam int         INJ_MAX    = 4;
   localparam int         WINDOW     = 16;
   localparam int         STARVE_LIM = 8;
   localparam logic [3:0] XC         = 4'd1;
   localparam logic [3:0] YC         = 4'd1;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  coreValid;
   logic [WIDTH_PORT-1:0] coreFlit;
   logic                  coreReady;
   logic [3:0]            linkValid;
   logic                  throttleEn;
   logic [WIDTH_PORT-1:0] dinLocal;
   logic [WIDTH_PV-1:0]   PVLocal;
   logic                  injValid;
   logic                  starve;

   int n_checks = 0;
   int n_fail   = 0;

   logic [WIDTH_PORT-1:0] m_q[$];
   int m_time, m_win, m_tok, m_blk;

   always #5 clk = ~clk;

   bless_inject_ctrl #(
      .DEPTH(DEPTH), .X_CUR(XC), .Y_CUR(YC),
      .INJ_MAX(INJ_MAX), .WINDOW(WINDOW), .STARVE_LIM(STARVE_LIM)
   ) dut (
      .clk(clk), .reset(reset), .coreValid(coreValid), .coreFlit(coreFlit),
      .coreReady(coreReady), .linkValid(linkValid), .throttleEn(throttleEn),
      .dinLocal(dinLocal), .PVLocal(PVLocal), .injValid(injValid), .starve(starve)
   );

   function automatic logic [WIDTH_PORT-1:0] mk_flit(input int x, input int y);
      return {6'($urandom), 2'($urandom), 8'($urandom), 4'(x), 4'(y), WIDTH_DATA'($urandom)};
   endfunction

   function automatic logic [WIDTH_PORT-1:0] stamp(input logic [WIDTH_PORT-1:0] f, input int t);
      return {f[WIDTH_PORT-1 -: 8], 8'(t), f[WIDTH_PORT-17:0]};
   endfunction

   function automatic bit exp_inj();
      return (m_q.size() > 0) && ($countones(linkValid) < 4) && (!throttleEn || m_tok > 0);
   endfunction

   function automatic logic [WIDTH_PORT-1:0] exp_din();
      if (!exp_inj()) return '0;
      return stamp(m_q[0], m_time);
   endfunction

   function automatic logic [WIDTH_PV-1:0] exp_pv();
      int x, y;
      logic [WIDTH_PV-1:0] pv;
      if (!exp_inj()) return '0;
      x  = int'(m_q[0][WIDTH_DATA+4 +: 4]);
      y  = int'(m_q[0][WIDTH_DATA +: 4]);
      pv = '0;
      if (x > int'(XC)) pv[1] = 1'b1;
      if (x < int'(XC)) pv[0] = 1'b1;
      if (y > int'(YC)) pv[3] = 1'b1;
      if (y < int'(YC)) pv[2] = 1'b1;
      if (x == int'(XC) && y == int'(YC)) pv[4] = 1'b1;
      return pv;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_time = 0;
      m_win  = 0;
      m_tok  = INJ_MAX;
      m_blk  = 0;
   endtask

   task automatic model_edge();
      bit inj, push;
      int sz;
      inj  = exp_inj();
      sz   = m_q.size();
      push = coreValid && (sz < DEPTH);
      if (inj) void'(m_q.pop_front());
      if (push) m_q.push_back(coreFlit);
      m_time = (m_time + 1) % 256;
      if (m_win == WINDOW - 1) begin
         m_win = 0;
         m_tok = INJ_MAX;
      end else begin
         m_win++;
         if (inj && m_tok > 0) m_tok--;
      end
      if (sz > 0 && !inj) m_blk = (m_blk + 1 > STARVE_LIM) ? STARVE_LIM : m_blk + 1;
      else m_blk = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; coreValid = 1'b0; coreFlit = '0; linkValid = '0; throttleEn = 1'b0;
      model_reset();
      #7;
      n_checks++;
      if (coreReady !== 1'b1 || injValid !== 1'b0 || dinLocal !== '0 || PVLocal !== '0) begin
         n_fail++;
         $display("FAIL reset_hold: ready=%b inj=%b din=%h pv=%b required ready=1 inj=0 din=0 pv=0",
                  coreReady, injValid, dinLocal, PVLocal);
      end
      #3 reset = 1'b1;
      #1;
      n_checks++;
      if (coreReady !== 1'b1 || injValid !== 1'b0 || starve !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: ready=%b inj=%b starve=%b required 1 0 0", coreReady, injValid, starve);
      end
   endtask

   task automatic test_route();
      int xs[3] = '{3, 0, 1};
      int ys[3] = '{1, 0, 1};
      logic [WIDTH_PV-1:0] pv_req[3] = '{5'b00010, 5'b00101, 5'b10000};
      logic [WIDTH_PORT-1:0] f;
      throttleEn = 1'b0;
      for (int i = 0; i < 3; i++) begin
         f = mk_flit(xs[i], ys[i]);
         coreValid = 1'b1; coreFlit = f; linkValid = 4'b0011;
         #1;
         n_checks++;
         if (injValid !== 1'b0) begin
            n_fail++;
            $display("FAIL route_%0d_same_cycle: inj=%b required 0", i, injValid);
         end
         tick();
         coreValid = 1'b0;
         #1;
         n_checks++;
         if (injValid !== 1'b1 || PVLocal !== pv_req[i] || dinLocal !== stamp(f, m_time)) begin
            n_fail++;
            $display("FAIL route_%0d: inj=%b pv=%b din=%h required inj=1 pv=%b din=%h",
                     i, injValid, PVLocal, dinLocal, pv_req[i], stamp(f, m_time));
         end
         tick();
      end
   endtask

   task automatic test_starve();
      throttleEn = 1'b0;
      coreValid = 1'b1; coreFlit = mk_flit($urandom_range(0, 15), $urandom_range(0, 15)); linkValid = 4'hF;
      tick();
      coreValid = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         #1;
         n_checks++;
         if (injValid !== 1'b0 || starve !== (c >= 9)) begin
            n_fail++;
            $display("FAIL starve_cycle_%0d: inj=%b starve=%b required inj=0 starve=%b", c, injValid, starve, c >= 9);
         end
         tick();
      end
      linkValid = 4'h0;
      #1;
      n_checks++;
      if (injValid !== 1'b1) begin
         n_fail++;
         $display("FAIL starve_release_inject: inj=%b required 1", injValid);
      end
      tick();
      n_checks++;
      if (starve !== 1'b0 || injValid !== 1'b0) begin
         n_fail++;
         $display("FAIL starve_clear: starve=%b inj=%b required 0 0", starve, injValid);
      end
   endtask

   task automatic test_full();
      logic [WIDTH_PORT-1:0] pushed[4];
      throttleEn = 1'b0; linkValid = 4'hF;
      for (int i = 0; i < 4; i++) begin
         pushed[i] = mk_flit($urandom_range(0, 15), $urandom_range(0, 15));
         coreValid = 1'b1; coreFlit = pushed[i];
         #1;
         n_checks++;
         if (coreReady !== 1'b1) begin
            n_fail++;
            $display("FAIL full_fill_%0d: ready=%b required 1", i, coreReady);
         end
         tick();
      end
      coreFlit = mk_flit(2, 2); linkValid = 4'h0;
      #1;
      n_checks++;
      if (coreReady !== 1'b0 || injValid !== 1'b1 || dinLocal !== stamp(pushed[0], m_time)) begin
         n_fail++;
         $display("FAIL full_push_pop: ready=%b inj=%b din=%h required ready=0 inj=1 din=%h",
                  coreReady, injValid, dinLocal, stamp(pushed[0], m_time));
      end
      tick();
      coreValid = 1'b0;
      #1;
      n_checks++;
      if (coreReady !== 1'b1) begin
         n_fail++;
         $display("FAIL full_count3: ready=%b required 1", coreReady);
      end
      for (int i = 1; i < 4; i++) begin
         n_checks++;
         if (injValid !== 1'b1 || dinLocal !== stamp(pushed[i], m_time)) begin
            n_fail++;
            $display("FAIL full_drain_%0d: inj=%b din=%h required inj=1 din=%h",
                     i, injValid, dinLocal, stamp(pushed[i], m_time));
         end
         tick();
      end
      n_checks++;
      if (injValid !== 1'b0) begin
         n_fail++;
         $display("FAIL full_drained: inj=%b required 0", injValid);
      end
   endtask

   task automatic test_throttle();
      int cnt, guard;
      throttleEn = 1'b1; linkValid = 4'h0; coreValid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         coreFlit = mk_flit($urandom_range(0, 15), $urandom_range(0, 15));
         tick();
      end
      guard = 0;
      while (m_win != 0 && guard < 64) begin
         coreFlit = mk_flit($urandom_range(0, 15), $urandom_range(0, 15));
         tick();
         guard++;
      end
      n_checks++;
      if (guard >= 64) begin
         n_fail++;
         $display("FAIL throttle_align: window start not reached after %0d cycles", guard);
      end
      for (int w = 0; w < 3; w++) begin
         cnt = 0;
         for (int c = 0; c < WINDOW; c++) begin
            coreFlit = mk_flit($urandom_range(0, 15), $urandom_range(0, 15));
            #1;
            if (injValid === 1'b1) cnt++;
            n_checks++;
            if (injValid !== exp_inj()) begin
               n_fail++;
               $display("FAIL throttle_w%0d_c%0d: inj=%b required %b", w, c, injValid, exp_inj());
            end
            tick();
         end
         n_checks++;
         if (cnt != INJ_MAX) begin
            n_fail++;
            $display("FAIL throttle_window_%0d: injections=%0d required %0d", w, cnt, INJ_MAX);
         end
      end
   endtask

   task automatic test_random();
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (cyc == 300) begin
            reset = 1'b0;
            model_reset();
            #1;
            n_checks++;
            if (coreReady !== 1'b1 || injValid !== 1'b0 || dinLocal !== '0 || PVLocal !== '0) begin
               n_fail++;
               $display("FAIL random_midreset: ready=%b inj=%b din=%h pv=%b required 1 0 0 0",
                        coreReady, injValid, dinLocal, PVLocal);
            end
            @(posedge clk);
            #1 reset = 1'b1;
         end
         if (cyc % 50 == 0) throttleEn = 1'($urandom_range(0, 1));
         coreValid = ($urandom_range(0, 9) < 6);
         coreFlit  = mk_flit($urandom_range(0, 15), $urandom_range(0, 15));
         linkValid = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
         #1;
         n_checks++;
         if (coreReady !== (m_q.size() < DEPTH) || injValid !== exp_inj() || dinLocal !== exp_din()
             || PVLocal !== exp_pv() || starve !== (m_blk >= STARVE_LIM)) begin
            n_fail++;
            $display("FAIL random_cyc_%0d: ready=%b inj=%b din=%h pv=%b starve=%b required %b %b %h %b %b",
                     cyc, coreReady, injValid, dinLocal, PVLocal, starve, m_q.size() < DEPTH,
                     exp_inj(), exp_din(), exp_pv(), m_blk >= STARVE_LIM);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_route();
      test_starve();
      test_full();
      test_throttle();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
